// File: rtl/lfsr_crc_stream.sv
// lfsr_crc_stream: framed byte-lane CRC engine (GEN / CHECK) built on parallel LFSR steps.
// Define LFSR_CRC_STREAM_STATS_EN to build the frame/error counters.

module lfsr #(
  parameter int                    LFSR_WIDTH  = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 32'h04c11db7,
  parameter string                 LFSR_CONFIG = "GALOIS",
  parameter bit                    REVERSE     = 1'b1,
  parameter int                    DATA_WIDTH  = 8,
  parameter string                 STYLE       = "AUTO"
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam bit FIB = (LFSR_CONFIG == "FIBONACCI");

  if (LFSR_CONFIG != "GALOIS" && LFSR_CONFIG != "FIBONACCI") begin : g_bad_cfg
    $error("lfsr: unsupported LFSR_CONFIG");
  end
  if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : g_bad_style
    $error("lfsr: unsupported STYLE");
  end

  function automatic logic [LFSR_WIDTH-1:0] rev(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    for (int i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
    return r;
  endfunction

  logic [LFSR_WIDTH-1:0] s;
  logic                  d;
  logic                  fb;

  // Bytes in wire order; REVERSE keeps the state in reflected form.
  always_comb begin
    s  = REVERSE ? rev(state_in) : state_in;
    d  = 1'b0;
    fb = 1'b0;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      for (int i = 0; i < 8; i++) begin
        d = REVERSE ? data_in[8*b+i] : data_in[8*b+7-i];
        if (FIB) begin
          fb = d ^ s[LFSR_WIDTH-1]
             ^ (^(s[LFSR_WIDTH-2:0] & LFSR_POLY[LFSR_WIDTH-1:1]));
          s  = {s[LFSR_WIDTH-2:0], fb};
        end else begin
          fb = d ^ s[LFSR_WIDTH-1];
          s  = {s[LFSR_WIDTH-2:0], 1'b0} ^ (fb ? LFSR_POLY : '0);
        end
      end
    end
    state_out = REVERSE ? rev(s) : s;
  end

endmodule

module lfsr_crc_stream #(
  parameter int                    LFSR_WIDTH    = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 32'h04c11db7,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT     = '1,
  parameter string                 LFSR_CONFIG   = "GALOIS",
  parameter bit                    REVERSE       = 1'b1,
  parameter bit                    INVERT        = 1'b1,
  parameter int                    DATA_WIDTH    = 64,
  parameter int                    KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter string                 MODE          = "GEN",
  parameter logic [LFSR_WIDTH-1:0] CHECK_RESIDUE = 32'h2144df1c,
  parameter string                 STYLE         = "AUTO"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [KEEP_WIDTH-1:0] s_keep,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  output logic [LFSR_WIDTH-1:0] crc_out,
  output logic                  crc_ok,
  output logic                  crc_valid,
  input  logic                  crc_ready,
  output logic                  busy,
  output logic [31:0]           frame_count,
  output logic [31:0]           err_count
);

  localparam int NW  = $clog2(KEEP_WIDTH + 1);
  localparam bit CHK = (MODE == "CHECK");

  if (MODE != "GEN" && MODE != "CHECK") begin : g_bad_mode
    $error("lfsr_crc_stream: unsupported MODE");
  end
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 512) begin : g_bad_dw
    $error("lfsr_crc_stream: bad DATA_WIDTH");
  end

  logic [LFSR_WIDTH-1:0]               state_reg;
  logic [KEEP_WIDTH:0][LFSR_WIDTH-1:0] step;
  logic [NW-1:0]                       n;
  logic [LFSR_WIDTH-1:0]               fin;
  logic [LFSR_WIDTH-1:0]               crc_nxt;
  logic                                ok_nxt;
  logic                                s_fire;

  // step[k] is the state after the first k bytes of the beat.
  assign step[0] = state_reg;

  for (genvar k = 1; k <= KEEP_WIDTH; k++) begin : g_lane
    lfsr #(
      .LFSR_WIDTH (LFSR_WIDTH),
      .LFSR_POLY  (LFSR_POLY),
      .LFSR_CONFIG(LFSR_CONFIG),
      .REVERSE    (REVERSE),
      .DATA_WIDTH (8 * k),
      .STYLE      (STYLE)
    ) u_lfsr (
      .data_in  (s_data[8*k-1:0]),
      .state_in (state_reg),
      .state_out(step[k])
    );
  end

  always_comb begin
    n = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      if (s_keep[k]) n = NW'(k + 1);
    end
  end

  assign fin     = step[n];
  assign crc_nxt = INVERT ? ~fin : fin;
  assign ok_nxt  = CHK && (crc_nxt == CHECK_RESIDUE);
  assign s_ready = !crc_valid || crc_ready;
  assign s_fire  = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LFSR_INIT;
      crc_out   <= '0;
      crc_ok    <= 1'b0;
      crc_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (crc_valid && crc_ready) crc_valid <= 1'b0;
      if (s_fire) begin
        if (s_last) begin
          crc_out   <= crc_nxt;
          crc_ok    <= ok_nxt;
          crc_valid <= 1'b1;
          state_reg <= LFSR_INIT;
          busy      <= 1'b0;
        end else begin
          state_reg <= step[KEEP_WIDTH];
          busy      <= 1'b1;
        end
      end
    end
  end

`ifdef LFSR_CRC_STREAM_STATS_EN
  logic [31:0] frames_q;
  logic [31:0] errs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= '0;
      errs_q   <= '0;
    end else if (s_fire && s_last) begin
      frames_q <= frames_q + 32'd1;
      if (CHK && !ok_nxt) errs_q <= errs_q + 32'd1;
    end
  end

  assign frame_count = frames_q;
  assign err_count   = errs_q;
`else
  assign frame_count = '0;
  assign err_count   = '0;
`endif

endmodule

// File: tb/tb_lfsr_crc_stream.sv
// tb_lfsr_crc_stream: scoreboard bench for a GEN (64-bit) and a CHECK (8-bit) instance.
// Expected CRCs come from a bitwise reflected CRC-32 model or known reference values.

module tb_lfsr_crc_stream;

  typedef logic [7:0] bq_t[$];

  localparam logic [31:0] RES = 32'h2144df1c;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] g_data;
  logic [7:0]  g_keep;
  logic        g_valid, g_rdy, g_last;
  logic [31:0] g_crc;
  logic        g_ok, g_cv, g_crdy, g_busy;
  logic [31:0] g_fc, g_ec;

  logic [7:0]  c_data;
  logic [0:0]  c_keep;
  logic        c_valid, c_rdy, c_last;
  logic [31:0] c_crc;
  logic        c_ok, c_cv, c_crdy, c_busy;
  logic [31:0] c_fc, c_ec;

  lfsr_crc_stream u_gen (
    .clk(clk), .rst(rst),
    .s_data(g_data), .s_keep(g_keep), .s_valid(g_valid),
    .s_ready(g_rdy), .s_last(g_last),
    .crc_out(g_crc), .crc_ok(g_ok), .crc_valid(g_cv),
    .crc_ready(g_crdy), .busy(g_busy),
    .frame_count(g_fc), .err_count(g_ec)
  );

  lfsr_crc_stream #(.DATA_WIDTH(8), .MODE("CHECK")) u_chk (
    .clk(clk), .rst(rst),
    .s_data(c_data), .s_keep(c_keep), .s_valid(c_valid),
    .s_ready(c_rdy), .s_last(c_last),
    .crc_out(c_crc), .crc_ok(c_ok), .crc_valid(c_cv),
    .crc_ready(c_crdy), .busy(c_busy),
    .frame_count(c_fc), .err_count(c_ec)
  );

  logic [32:0] gq[$];
  logic [32:0] cq[$];
  bq_t         gbytes;
  bq_t         cbytes;
  int          gframes = 0;
  int          cframes = 0;
  int          cerrs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input bq_t q);
    logic [31:0] c;
    c = '1;
    foreach (q[i]) begin
      c ^= {24'd0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hedb88320 : c >> 1;
    end
    return ~c;
  endfunction

  function automatic logic [63:0] str8(input string s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  // Results are consumed at the next posedge; pop exactly once per result.
  logic [32:0] ge, ce;
  always @(negedge clk) begin
    if (!rst && g_cv && g_crdy) begin
      if (gq.size() == 0) chk("g_unexp", 1, 0);
      else begin
        ge = gq.pop_front();
        chk("g_crc", g_crc, ge[31:0]);
        chk("g_ok", g_ok, ge[32]);
      end
    end
  end
  always @(negedge clk) begin
    if (!rst && c_cv && c_crdy) begin
      if (cq.size() == 0) chk("c_unexp", 1, 0);
      else begin
        ce = cq.pop_front();
        chk("c_crc", c_crc, ce[31:0]);
        chk("c_ok", c_ok, ce[32]);
      end
    end
  end

  task automatic g_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                        input bit lat, input bit use_ref, input logic [31:0] rf);
    int  nb;
    bit  got;
    logic [31:0] v;
    g_data = d; g_keep = k; g_last = l; g_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (g_rdy) begin got = 1'b1; break; end
    end
    if (!got) chk("g_rdy_to", 0, 1);
    @(posedge clk); #1;
    g_valid = 1'b0;
    nb = 8;
    if (l) begin
      nb = 0;
      for (int i = 0; i < 8; i++) if (k[i]) nb = i + 1;
    end
    for (int i = 0; i < nb; i++) gbytes.push_back(d[8*i +: 8]);
    if (l) begin
      v = use_ref ? rf : crc32(gbytes);
      gq.push_back({1'b0, v});
      gbytes.delete();
      gframes++;
      if (lat) begin
        @(negedge clk);
        chk("g_lat", g_cv, 1);
        chk("g_busy_end", g_busy, 0);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic c_beat(input logic [7:0] d, input logic l,
                        input bit use_ref, input logic [32:0] rf);
    bit  got;
    logic [31:0] v;
    logic [32:0] e;
    c_data = d; c_last = l; c_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (c_rdy) begin got = 1'b1; break; end
    end
    if (!got) chk("c_rdy_to", 0, 1);
    @(posedge clk); #1;
    c_valid = 1'b0;
    cbytes.push_back(d);
    if (l) begin
      v = crc32(cbytes);
      e = use_ref ? rf : {v == RES, v};
      cq.push_back(e);
      cbytes.delete();
      cframes++;
      if (!e[32]) cerrs++;
    end
  endtask

  task automatic c_frame(input string s, input bit flip);
    bq_t q;
    logic [31:0] f;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    f = crc32(q);
    if (flip) q[0] = q[0] ^ 8'h01;
    for (int i = 0; i < 4; i++) q.push_back(f[8*i +: 8]);
    foreach (q[i]) c_beat(q[i], i == q.size() - 1, 1'b0, '0);
  endtask

  task automatic chk_counts();
`ifdef LFSR_CRC_STREAM_STATS_EN
    chk("g_frames", g_fc, 64'(gframes));
    chk("c_frames", c_fc, 64'(cframes));
    chk("c_errs", c_ec, 64'(cerrs));
`else
    chk("g_frames", g_fc, 0);
    chk("c_frames", c_fc, 0);
    chk("c_errs", c_ec, 0);
`endif
    chk("g_errs", g_ec, 0);
  endtask

  initial begin
    bq_t q;
    logic [31:0] ca, cb;
    int c0;
    rst = 1'b1;
    g_data = '0; g_keep = '0; g_valid = 1'b0; g_last = 1'b0; g_crdy = 1'b1;
    c_data = '0; c_keep = 1'b1; c_valid = 1'b0; c_last = 1'b0; c_crdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cv", g_cv, 0);
    chk("rst_crc", g_crc, 0);
    chk("rst_ok", g_ok, 0);
    chk("rst_busy", g_busy, 0);
    chk("rst_rdy", g_rdy, 1);
    chk("rst_c_cv", c_cv, 0);
    chk_counts();
    @(posedge clk); #1;

    // CHECK: reference frame, corrupted frame, random frame with its FCS.
    q = {"1","2","3","4","5","6","7","8","9", 8'h26, 8'h39, 8'hf4, 8'hcb};
    foreach (q[i]) c_beat(q[i], i == 12, i == 12, {1'b1, RES});
    c_frame("123456789", 1'b1);
    c_frame("lfsr frame x", 1'b0);
    repeat (3) @(posedge clk); #1;
    chk_counts();

    // GEN: two-beat reference frame.
    g_beat(str8("12345678"), 8'hff, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("g_busy_mid", g_busy, 1);
    @(posedge clk); #1;
    g_beat(str8("9"), 8'h01, 1'b1, 1'b1, 1'b1, 32'hcbf43926);

    // Empty keep on the last beat.
    g_beat(str8("12345678"), 8'hff, 1'b0, 1'b0, 1'b0, '0);
    g_beat(64'hdead_beef_0bad_f00d, 8'h00, 1'b1, 1'b1, 1'b1, 32'h9ae0daaf);

    // Backpressure.
    repeat (2) @(posedge clk); #1;
    q = {"A"}; ca = crc32(q);
    q = {"B"}; cb = crc32(q);
    g_crdy = 1'b0;
    g_beat(str8("A"), 8'h01, 1'b1, 1'b1, 1'b0, '0);
    g_data = str8("B"); g_keep = 8'h01; g_last = 1'b1; g_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_rdy", g_rdy, 0);
      chk("bp_hold", g_crc, 64'(ca));
      chk("bp_cv", g_cv, 1);
    end
    @(posedge clk); #1;
    g_crdy = 1'b1;
    #1 chk("bp_rdy_up", g_rdy, 1);
    @(posedge clk); #1;
    g_valid = 1'b0;
    gq.push_back({1'b0, cb});
    gframes++;

    // Back-to-back one-beat frames at full rate.
    @(posedge clk); #1;
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      g_beat({$urandom, $urandom}, 8'hff >> $urandom_range(0, 7), 1'b1, 1'b0, 1'b0, '0);
    chk("b2b_cyc", 64'(cyc - c0), 8);

    // Random multi-beat frames.
    for (int f = 0; f < 4; f++) begin
      for (int b = $urandom_range(0, 3); b > 0; b--)
        g_beat({$urandom, $urandom}, 8'hff, 1'b0, 1'b0, 1'b0, '0);
      g_beat({$urandom, $urandom}, 8'hff >> $urandom_range(0, 7), 1'b1, 1'b0, 1'b0, '0);
    end
    repeat (3) @(posedge clk); #1;
    chk_counts();

    // Reset mid-frame discards the partial frame.
    g_beat({$urandom, $urandom}, 8'hff, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("rst_mid_busy", g_busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    gbytes.delete();
    gframes = 0; cframes = 0; cerrs = 0;
    @(negedge clk);
    chk("rst2_busy", g_busy, 0);
    chk("rst2_cv", g_cv, 0);
    chk_counts();
    @(posedge clk); #1;
    g_beat(str8("12345678"), 8'hff, 1'b0, 1'b0, 1'b0, '0);
    g_beat(str8("9"), 8'h01, 1'b1, 1'b1, 1'b1, 32'hcbf43926);
    repeat (3) @(posedge clk); #1;
    chk_counts();
    chk("g_drain", 64'(gq.size()), 0);
    chk("c_drain", 64'(cq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_crc_stream.md
# lfsr_crc_stream

Framed, multi-byte CRC engine: successor to the single-word CRC register. Accepts a byte-lane stream (valid/ready, last, keep) of DATA_WIDTH bits per beat, folds each accepted beat into a running LFSR state, and on the final beat of a frame delivers the finished CRC through a one-entry output register with its own valid/ready handshake. Used at MAC TX (MODE "GEN", FCS to append) and MAC RX (MODE "CHECK", pass/fail per frame).

## Interface
- LFSR_WIDTH, 32: CRC register width.
- LFSR_POLY, 32'h04c11db7: polynomial, top term implied.
- LFSR_INIT, all ones: state at reset and at start of every frame.
- LFSR_CONFIG, "GALOIS": "GALOIS" or "FIBONACCI", passed to the `lfsr` instances.
- REVERSE, 1: LSB-first bit order within each byte.
- INVERT, 1: invert crc_out.
- DATA_WIDTH, 64: beat width, a multiple of 8, 8..512.
- KEEP_WIDTH, DATA_WIDTH/8: byte lanes.
- MODE, "GEN": "GEN" or "CHECK".
- CHECK_RESIDUE, 32'h2144df1c: expected post-INVERT crc_out over data plus FCS (CHECK only).
- STYLE, "AUTO": passed to the `lfsr` instances.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_WIDTH  input beat; byte 0 = bits [7:0] is first on the wire.
- s_keep  in  KEEP_WIDTH  byte enables; honoured only when s_last=1.
- s_valid  in  1  beat valid.
- s_ready  out  1  beat accepted when s_valid && s_ready.
- s_last  in  1  final beat of frame.
- crc_out  out  LFSR_WIDTH  finished CRC, after INVERT.
- crc_ok  out  1  CHECK: crc_out == CHECK_RESIDUE; GEN: constant 0.
- crc_valid  out  1  output register holds a result.
- crc_ready  in  1  result consumed when crc_valid && crc_ready.
- busy  out  1  mid-frame: at least one non-last beat accepted, last not yet accepted.
- frame_count  out  32  frames completed (see Configuration).
- err_count  out  32  CHECK frames with crc_ok=0 (see Configuration).

## Operation
- Build KEEP_WIDTH combinational `lfsr` instances; instance k has DATA_WIDTH 8*k and consumes bytes 0..k-1. All share state_in = state_reg.
- Non-last accepted beat: state_reg <= result of the full-width instance, regardless of s_keep. busy <= 1.
- Last accepted beat: n = index of the highest set bit of s_keep, plus 1.
  - s_keep must be contiguous from bit 0. Non-contiguous keep uses the highest set bit; it is not flagged.
  - n=0 (keep all zero): the CRC is that of the state held before the beat.
  - Final state F = result of instance n.
  - crc_out <= INVERT ? ~F : F; crc_ok <= (MODE=="CHECK") && (crc_out value == CHECK_RESIDUE); crc_valid <= 1.
  - state_reg <= LFSR_INIT; busy <= 0.
- s_ready = !crc_valid || crc_ready. Output is overwritten only when empty or being consumed in the same cycle, so no result is ever lost.
- crc_valid clears on crc_ready unless a new last beat is accepted in the same cycle; in that case it stays 1 with the new result.
- Reset values: state_reg = LFSR_INIT; crc_out = 0; crc_ok = 0; crc_valid = 0; busy = 0; counters = 0. Reset mid-frame discards the partial frame. The next beat starts a fresh frame.

## Timing
- s_ready is combinational from crc_valid/crc_ready only, with no path from s_valid.
- The result appears one cycle after acceptance of the last beat. crc_out and crc_ok are stable while crc_valid && !crc_ready.
- Full throughput: one beat per cycle, with back-to-back frames and no gap, provided crc_ready=1.
- One-beat frame (s_last on first beat): CRC is computed from LFSR_INIT, result after 1 cycle.

## Configuration
- LFSR_CRC_STREAM_STATS_EN defined:
  - frame_count increments on each accepted last beat.
  - err_count increments on each accepted last beat that yields crc_ok=0 in MODE "CHECK".
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Not defined: both ports are tied to constant 0 and no counter logic is built.

## Test plan
- GEN, DATA_WIDTH 64: beat "12345678" (s_keep ff, not last), then beat "9" (s_keep 01, last) -> crc_out 32'hcbf43926, crc_valid 1 cycle after acceptance.
- CHECK, DATA_WIDTH 8: "123456789" followed by bytes 26 39 f4 cb, last on cb -> crc_out 32'h2144df1c, crc_ok 1. Flip one data bit -> crc_ok 0, err_count +1 with the macro defined.
- Backpressure: crc_ready=0 with a result held -> s_ready 0. The next frame's beats stall and crc_out does not change. Raise crc_ready -> s_ready is 1 in the same cycle and the stalled beat is accepted.
- Back-to-back one-beat frames with crc_ready=1 -> one result per cycle. Each result is computed from LFSR_INIT, with no state carried between frames.
- s_keep 00 on the last beat after "12345678" -> crc_out equals the CRC of "12345678" (32'h9ae0daaf).
- Reset asserted mid-frame, then frame "123456789" -> crc_out 32'hcbf43926, busy 0 after reset, and frame_count counts only completed frames.
